seq_priority_decoder: RTL and testbench

Sequential decoder for the 2-bit priority code produced by the 3-input priority encoder. It accepts codes over a valid/ready handshake, buffers them in a small FIFO, and replays each code as a one-hot grant on three lines. Each grant is held for a fixed number of cycles and followed by a one-cycle all-low gap. It sits at the consumer end of the encoder path and drives per-channel enables.

---
 rtl/seq_priority_decoder_if.sv | 12 +
 rtl/seq_priority_decoder.sv | 136 +++++++++++++
 tb/tb_seq_priority_decoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_priority_decoder_if.sv
// Valid/ready link carrying a 2-bit priority code from the encoder to the decoder.
// Latency: none, plain wires.
// Backpressure: the source holds in_valid/in1/in0 stable until it sees in_ready high at a clock edge.
interface seq_priority_decoder_if;
    logic in_valid;
    logic in1;
    logic in0;
    logic in_ready;

    modport master (output in_valid, in1, in0, input in_ready);
    modport slave  (input in_valid, in1, in0, output in_ready);
endinterface

// File: rtl/seq_priority_decoder.sv
// Buffers 2-bit priority codes and replays each one as a HOLD_CYCLES-wide one-hot grant plus a 1-cycle gap.
// Latency: a code accepted at edge E0 into an empty, idle block shows its grant after edge E0+1.
// Backpressure: in_ready drops while FIFO_DEPTH codes are buffered; null code 00 is always sunk.
module seq_priority_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_priority_decoder_if.slave  code,
    output logic                   out2,
    output logic                   out1,
    output logic                   out0,
    output logic                   busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [3:0]    HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [2:0]    grant, grant_next;
    logic [3:0]    hold, hold_next;
    logic [1:0]    in_code;
    logic          ready;
    logic          push;
    logic          pop;

    // Codes are stored raw; the one-hot form only exists in the grant register.
    function automatic logic [2:0] decode(input logic [1:0] c);
        case (c)
            2'b01:   decode = 3'b001;
            2'b10:   decode = 3'b010;
            2'b11:   decode = 3'b100;
            default: decode = 3'b000;
        endcase
    endfunction

    assign in_code       = {code.in1, code.in0};
    // Full-only check on the registered count: a pop never makes room in the same cycle.
    assign ready         = (count != FULL);
    assign code.in_ready = ready;
    // Null code completes the handshake but is never stored.
    assign push          = code.in_valid && ready && (in_code != 2'b00);

    assign {out2, out1, out0} = grant;

    // Occupancy after this edge's push/pop; simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // FIFO storage, pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 2'b00;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_code;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Grant sequencer: pop and load from IDLE or GAP, hold for HOLD_CYCLES, then one low cycle.
    always_comb begin
        state_next = state;
        grant_next = grant;
        hold_next  = hold;
        pop        = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    grant_next = decode(mem[rd_ptr]);
                    hold_next  = HOLD_LOAD;
                    state_next = GRANT;
                end else begin
                    grant_next = 3'b000;
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (hold == 4'd0) begin
                    grant_next = 3'b000;
                    state_next = GAP;
                end else begin
                    hold_next = hold - 4'd1;
                end
            end
            default: begin
                grant_next = 3'b000;
                hold_next  = 4'd0;
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer state, grant and busy registers; reset drops the grants without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 3'b000;
            hold  <= 4'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            hold  <= hold_next;
            busy  <= (state_next != IDLE) || (count_next != '0);
        end
    end
endmodule

// File: tb/tb_seq_priority_decoder.sv
// Bench for seq_priority_decoder: vector table, hand-written timing sequences and a grant scoreboard.
// Latency: n/a.
// Backpressure: the driver holds each code until in_ready is seen high at an edge.
module tb_seq_priority_decoder;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] code;
        logic [2:0] grant;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic out2, out1, out0, busy;

    seq_priority_decoder_if dif();

    seq_priority_decoder #(
        .HOLD_CYCLES (HOLD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (dif),
        .out2  (out2),
        .out1  (out1),
        .out0  (out0),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [2:0] exp_q[$];
    int         start_q[$];
    logic [2:0] g_prev = 3'b000;
    int         run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] c);
        logic [2:0] one;
        one = 3'b001;
        return (c == 2'b00) ? 3'b000 : (one << (c - 2'd1));
    endfunction

    // Scoreboard: every rising grant must match the oldest accepted code; widths and exclusivity checked.
    always @(negedge clk) begin
        logic [2:0] g;
        g = {out2, out1, out0};
        if (!rst_n) begin
            g_prev = 3'b000;
            run    = 0;
        end else begin
            check("onehot", 32'($countones(g) <= 1), 1);
            if (g != 3'b000 && g_prev == 3'b000) begin
                check("grant_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("grant_order", g, exp_q.pop_front());
                start_q.push_back(cyc);
                run = 1;
            end else if (g != 3'b000) begin
                check("grant_stable", g, g_prev);
                run++;
            end else if (g_prev != 3'b000) begin
                check("grant_width", run, HOLD);
            end
            g_prev = g;
        end
    end

    // Called just after a rising edge; returns after the edge on which the code was accepted.
    task automatic send(input logic [1:0] c, output int acc, output int stalls);
        bit   done;
        logic rdy;
        done   = 0;
        acc    = -1;
        stalls = 0;
        dif.in_valid = 1'b1;
        dif.in1      = c[1];
        dif.in0      = c[0];
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            rdy = dif.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                acc  = cyc;
                if (c != 2'b00) exp_q.push_back(onehot(c));
            end else begin
                stalls++;
            end
        end
        check("send_accepted", 32'(done), 1);
    endtask

    task automatic idle_inputs();
        dif.in_valid = 1'b0;
        dif.in1      = 1'b0;
        dif.in0      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && (busy !== 1'b0 || exp_q.size() != 0)) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(busy === 1'b0 && exp_q.size() == 0), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vec[4];
        int         acc, stalls, acc_first, lat;
        logic [2:0] got;
        bit         seen;

        vec[0] = '{code: 2'b01, grant: 3'b001};
        vec[1] = '{code: 2'b10, grant: 3'b010};
        vec[2] = '{code: 2'b11, grant: 3'b100};
        vec[3] = '{code: 2'b00, grant: 3'b000};

        idle_inputs();
        #2;
        check("rst_grants", {out2, out1, out0}, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", dif.in_ready, 1);
        #10 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_grants", {out2, out1, out0}, 0);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;

        // Table: each code alone, first grant value and latency; null code leaves block idle.
        foreach (vec[i]) begin
            send(vec[i].code, acc, stalls);
            idle_inputs();
            seen = 0;
            got  = 3'b000;
            lat  = -1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (!seen && {out2, out1, out0} != 3'b000) begin
                    seen = 1;
                    got  = {out2, out1, out0};
                    lat  = cyc - acc;
                end
            end
            check("vec_grant", got, vec[i].grant);
            if (vec[i].grant != 3'b000) check("vec_latency", lat, 1);
            else check("null_busy", busy, 0);
            wait_idle(40);
        end

        // Single code 10: out1 high for exactly HOLD cycles, busy clears after the gap cycle.
        send(2'b10, acc, stalls);
        idle_inputs();
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check("single_out1", out1, 32'(k >= 1 && k <= HOLD));
            check("single_busy", busy, 32'(k <= HOLD + 1));
        end
        wait_idle(40);

        // Burst 01,11,10: grant starts spaced HOLD+1 apart.
        start_q.delete();
        send(2'b01, acc, stalls);
        send(2'b11, acc, stalls);
        send(2'b10, acc, stalls);
        idle_inputs();
        wait_idle(100);
        check("burst_count", start_q.size(), 3);
        for (int i = 1; i < start_q.size(); i++) check("burst_spacing", start_q[i] - start_q[i-1], HOLD + 1);

        // Full FIFO: sixth code stalls two cycles and is accepted the edge after the second pop.
        send(2'b01, acc_first, stalls);
        send(2'b10, acc, stalls);
        send(2'b11, acc, stalls);
        send(2'b01, acc, stalls);
        send(2'b10, acc, stalls);
        check("full_no_stall", stalls, 0);
        send(2'b11, acc, stalls);
        idle_inputs();
        check("full_stalls", stalls, 2);
        check("full_accept_edge", acc - acc_first, HOLD + 3);
        wait_idle(200);

        // Wrap-around: 12 codes with in_valid held high, order and spacing preserved.
        start_q.delete();
        for (int i = 0; i < 12; i++) send(2'($urandom_range(1, 3)), acc, stalls);
        idle_inputs();
        wait_idle(300);
        check("wrap_count", start_q.size(), 12);
        for (int i = 1; i < start_q.size(); i++) check("wrap_spacing", start_q[i] - start_q[i-1], HOLD + 1);

        // Reset mid-grant: grants drop without a clock edge and buffered codes vanish.
        send(2'b01, acc, stalls);
        send(2'b10, acc, stalls);
        send(2'b11, acc, stalls);
        idle_inputs();
        @(negedge clk);
        check("pre_reset_out0", out0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_grants", {out2, out1, out0}, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", dif.in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_ready", dif.in_ready, 1);
        check("rst_hold_grants", {out2, out1, out0}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_grants", {out2, out1, out0}, 0);
        check("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
